// File: rtl/uart_rx_framer.sv
// UART receiver for 10-bit frames: start, 7 data bits LSB first, even parity, stop.
// Samples each bit at mid-period and reports data with parity and framing status.
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [6:0] data_out,
  output logic       valid_out,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [6:0]      shift_q;
  logic            par_q;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic            rx_prev_q;
  logic [6:0]      data_q;
  logic            valid_q;
  logic            perr_q;
  logic            ferr_q;
  logic            busy_q;

  // Synchronizer and edge history reset to the idle-line level so a reset
  // never fabricates a falling edge on a high line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // NOTE: non-blocking assignments everywhere in clocked logic, so every
  // register sees the pre-edge value of its neighbours regardless of order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Requires a real 1->0 transition; a line held low stays idle.
          if (rx_prev_q && !rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_q <= '0;
            idx_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            if (idx_q == 3'd6) begin
              state_q <= PARITY;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            par_q   <= rx_s_q;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          // Frame is delivered even with errors; status travels with the data.
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= shift_q;
            perr_q  <= (^shift_q) ^ par_q;
            ferr_q  <= ~rx_s_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: table of clean/erroneous frames plus
// hand sequences for reset abort, start glitch, break and back-to-back frames.
module tb_uart_rx_framer;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [6:0] data_out;
  logic       valid_out;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_valid = 0;
  int         got_time[$];
  logic [6:0] got_data[$];
  logic       got_perr[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      n_valid++;
      got_time.push_back(cyc);
      got_data.push_back(data_out);
      got_perr.push_back(parity_err);
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      rx_in = b;
    end
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  function automatic logic [9:0] mk_frame(input logic [6:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
    logic [9:0] f;
    f = mk_frame(d, p, s);
    for (int k = 0; k < 10; k++) drive_bit(f[k], CPB);
  endtask

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [9:0] f;
    int base;
    int qb;

    vecs[0] = '{7'h0F, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{7'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{7'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{7'h2B, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{7'h40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{7'h33, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{7'h6A, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data_out", data_out, 7'h00);
    check("reset valid_out", valid_out, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy", busy, 1'b0);
    rst = 1'b1;
    idle(10);

    for (int i = 0; i < 8; i++) begin
      base = n_valid;
      f = mk_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      for (int k = 0; k < 5; k++) drive_bit(f[k], CPB);
      check($sformatf("vec%0d busy mid-frame", i), busy, 1'b1);
      for (int k = 5; k < 10; k++) drive_bit(f[k], CPB);
      idle(20);
      check($sformatf("vec%0d pulses", i), n_valid - base, 1);
      check($sformatf("vec%0d data_out", i), data_out, vecs[i].data);
      check($sformatf("vec%0d parity_err", i), parity_err, vecs[i].exp_perr);
      check($sformatf("vec%0d frame_err", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d busy after", i), busy, 1'b0);
      check($sformatf("vec%0d valid low after", i), valid_out, 1'b0);
    end

    // Reset pulse during d3 of a frame whose remaining bits are all high.
    base = n_valid;
    f = mk_frame(7'h79, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) drive_bit(f[k], CPB);
    drive_bit(f[4], 8);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rst mid data_out", data_out, 7'h00);
    check("rst mid valid_out", valid_out, 1'b0);
    check("rst mid parity_err", parity_err, 1'b0);
    check("rst mid frame_err", frame_err, 1'b0);
    check("rst mid busy", busy, 1'b0);
    drive_bit(f[4], 6);
    for (int k = 5; k < 10; k++) drive_bit(f[k], CPB);
    idle(40);
    check("rst abort pulses", n_valid - base, 0);
    check("rst abort busy", busy, 1'b0);
    send_frame(7'h12, 1'b0, 1'b1);
    idle(20);
    check("post-rst pulses", n_valid - base, 1);
    check("post-rst data_out", data_out, 7'h12);
    check("post-rst parity_err", parity_err, 1'b0);
    check("post-rst frame_err", frame_err, 1'b0);

    // Start glitch: 4 low cycles must be rejected at the half-bit sample.
    base = n_valid;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 2);
    check("glitch busy during", busy, 1'b1);
    idle(30);
    check("glitch busy after", busy, 1'b0);
    check("glitch pulses", n_valid - base, 0);
    check("glitch data held", data_out, 7'h12);

    // Stop bit 0 followed by a held-low line (break), then a clean frame.
    base = n_valid;
    send_frame(7'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    check("break pulses", n_valid - base, 1);
    check("break data_out", data_out, 7'h55);
    check("break frame_err", frame_err, 1'b1);
    check("break parity_err", parity_err, 1'b0);
    check("break busy", busy, 1'b0);
    idle(20);
    check("break no second frame", n_valid - base, 1);
    send_frame(7'h2A, 1'b1, 1'b1);
    idle(20);
    check("after break pulses", n_valid - base, 2);
    check("after break data_out", data_out, 7'h2A);
    check("after break frame_err", frame_err, 1'b0);
    check("after break parity_err", parity_err, 1'b0);

    // Back-to-back frames, no idle gap.
    base = n_valid;
    qb = got_time.size();
    send_frame(7'h7F, 1'b1, 1'b1);
    send_frame(7'h00, 1'b0, 1'b1);
    idle(20);
    check("b2b pulses", n_valid - base, 2);
    if (got_time.size() >= qb + 2) begin
      check("b2b spacing", got_time[qb+1] - got_time[qb], 160);
      check("b2b first data", got_data[qb], 7'h7F);
      check("b2b second data", got_data[qb+1], 7'h00);
      check("b2b first perr", got_perr[qb], 1'b0);
      check("b2b second perr", got_perr[qb+1], 1'b0);
    end
    check("b2b final data_out", data_out, 7'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port rx_in  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data_out  output  7  received data bits, d0 = LSB.
REQ-006 SHALL have port valid_out  output  1  one-cycle pulse, frame complete.
REQ-007 SHALL have port parity_err  output  1  even-parity mismatch on the last frame.
REQ-008 SHALL have port frame_err  output  1  stop bit sampled 0 on the last frame.
REQ-009 SHALL have port busy  output  1  high while not in IDLE.

Function
REQ-010 SHALL accept 10-bit frames: start(0), d0..d6 LSB first, even parity bit, stop(1), matching the 10-bit frame the team's uart_tx produces.
REQ-011 SHALL pass rx_in through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP with a bit-cycle counter (0..CLKS_PER_BIT-1) and a 3-bit data-bit index.
REQ-013 IDLE: SHALL go to START with counter=0 on a 1->0 transition of rx_s; a constantly-low line SHALL NOT trigger a start.
REQ-014 START: SHALL sample rx_s when counter = CLKS_PER_BIT/2-1; if 0, go to DATA with counter=0; if 1 (glitch), go to IDLE with no output change.
REQ-015 DATA: SHALL sample rx_s when counter = CLKS_PER_BIT-1, shift into d[index], and go to PARITY after index 6.
REQ-016 PARITY: SHALL sample one bit period later and store it.
REQ-017 STOP: SHALL sample one bit period later, then return to IDLE in the next cycle.
REQ-018 SHALL sample each bit at its mid-point: bit k (start = 0, stop = 9) is sampled CLKS_PER_BIT/2-1 + k*CLKS_PER_BIT cycles after the rx_s falling edge is seen.
REQ-019 In the cycle after the stop sample, SHALL update all of the following in one cycle: assert valid_out for exactly 1 cycle, load data_out, set parity_err = (^d[6:0]) XOR parity_bit, and set frame_err = ~stop_bit.
REQ-020 SHALL hold data_out, parity_err and frame_err until the next valid_out.
REQ-021 SHALL assert valid_out even when parity_err or frame_err is set; the data is delivered regardless.
REQ-022 After a frame_err with rx_s still low, SHALL remain IDLE until rx_s returns to 1 and a new falling edge occurs (break condition).
REQ-023 SHALL accept back-to-back frames: a start edge arriving immediately after the stop bit (no idle gap) SHALL be detected.
REQ-024 SHALL ignore rx_in activity during a frame except at the sample points.
REQ-025 SHALL keep busy = 1 from the START entry through the STOP sample cycle, and 0 otherwise.

Reset
REQ-026 While rst = 0, the block SHALL force: state = IDLE, counter and index = 0, synchronizer flops = 1, data_out = 0, valid_out = 0, parity_err = 0, frame_err = 0, busy = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no valid_out; after release, reception SHALL restart only on a new falling edge.
REQ-028 Reset SHALL take effect on the first clk edge with rst = 0 and has no asynchronous path.

Verification (CLKS_PER_BIT = 16)
REQ-029 Send frame 0,1111000,0,1 (data 7'h0F) -> one valid_out pulse; data_out = 7'h0F; parity_err = 0; frame_err = 0; busy = 0 afterwards.
REQ-030 Send data 7'h01 with parity bit 0 -> valid_out; data_out = 7'h01; parity_err = 1; frame_err = 0.
REQ-031 Send data 7'h55 with stop bit 0, then hold the line low for 40 cycles -> valid_out once, frame_err = 1, no second frame; the next proper frame 7'h2A is then received cleanly.
REQ-032 Drive rx_in low for 4 cycles, then high -> no valid_out; busy returns to 0 by the START half-bit sample.
REQ-033 Send two frames 7'h7F and 7'h00 with no idle gap -> two valid_out pulses 160 cycles apart, with the correct data each time.
REQ-034 Assert rst = 0 for 1 cycle during bit d3 of a frame -> no valid_out for that frame; all outputs return to their reset values; the next frame 7'h12 is received correctly.
